// File: rtl/wb_writer_if.sv
// Bus bundle between decode, the memory stage and the write-back stage.
// The slave modport is the wb_writer side; master is the driving side.
interface wb_writer_if;
  logic        iss_valid;
  logic        iss_wb;
  logic [3:0]  iss_rd;
  logic        iss_full;
  logic        ret_valid;
  logic        ret_wb;
  logic        ret_isLd;
  logic        ret_isCall;
  logic [3:0]  ret_rd;
  logic [31:0] pc_in;
  logic [31:0] alu_res;
  logic [31:0] ld_res;
  logic        isWb;
  logic [3:0]  rd_ra;
  logic [31:0] data;
  logic [15:0] pending;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [31:0] fwd_data;

  modport slave (
    input  iss_valid, iss_wb, iss_rd,
    input  ret_valid, ret_wb, ret_isLd, ret_isCall, ret_rd, pc_in, alu_res, ld_res,
    output iss_full, isWb, rd_ra, data, pending, fwd_valid, fwd_rd, fwd_data
  );

  modport master (
    output iss_valid, iss_wb, iss_rd,
    output ret_valid, ret_wb, ret_isLd, ret_isCall, ret_rd, pc_in, alu_res, ld_res,
    input  iss_full, isWb, rd_ra, data, pending, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/wb_writer.sv
// Write-back stage: result select, registered register-file write port and
// per-register pending-write scoreboard. Define WB_FWD_EN to drive the bypass.
module wb_writer #(
  parameter int PC_STEP = 4,
  parameter int CNT_W   = 3
) (
  input logic        clk,
  input logic        rst,
  wb_writer_if.slave wb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating up/down step; decrement at zero is a protocol error and holds.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec && cnt != CNT_MAX) r = cnt + 1'b1;
    else if (dec && !inc && cnt != '0) r = cnt - 1'b1;
    return r;
  endfunction

  logic [CNT_W-1:0] cnt_q [16];
  logic             full_c;
  logic [15:0]      pending_c;
  logic             iss_take_p0;
  logic             vld_p0;
  logic [3:0]       rd_p0;
  logic [31:0]      data_p0;
  logic [15:0]      inc_p0;
  logic [15:0]      dec_p0;
  logic             vld_p1;
  logic [3:0]       rd_p1;
  logic [31:0]      data_p1;

  // Stage p0: result select and scoreboard update strobes
  assign full_c      = (cnt_q[wb.iss_rd] == CNT_MAX);
  assign iss_take_p0 = wb.iss_valid & wb.iss_wb & ~full_c;
  assign vld_p0      = wb.ret_valid & wb.ret_wb;

  always_comb begin
    rd_p0   = wb.ret_rd;
    data_p0 = wb.alu_res;
    if (wb.ret_isCall) begin
      rd_p0   = 4'd15;
      data_p0 = wb.pc_in + 32'(PC_STEP);
    end else if (wb.ret_isLd) begin
      data_p0 = wb.ld_res;
    end
  end

  always_comb begin
    inc_p0 = '0;
    dec_p0 = '0;
    if (iss_take_p0) inc_p0[wb.iss_rd] = 1'b1;
    if (vld_p0)      dec_p0[rd_p0]     = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_next(cnt_q[i], inc_p0[i], dec_p0[i]);
    end
  end

  always_comb begin
    pending_c = '0;
    for (int i = 0; i < 16; i++) pending_c[i] = (cnt_q[i] != '0);
  end

  // Stage p1: registered register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign wb.iss_full = full_c;
  assign wb.pending  = pending_c;
  assign wb.isWb     = vld_p1;
  assign wb.rd_ra    = rd_p1;
  assign wb.data     = data_p1;

`ifdef WB_FWD_EN
  assign wb.fwd_valid = vld_p1;
  assign wb.fwd_rd    = rd_p1;
  assign wb.fwd_data  = data_p1;
`else
  assign wb.fwd_valid = 1'b0;
  assign wb.fwd_rd    = '0;
  assign wb.fwd_data  = '0;
`endif

endmodule
